gate_door_ctrl: RTL and testbench
=================================

Name: gate_door_ctrl

Overview:
- Downstream of the fare-gate decision FSM: consumes its `open` output and drives the physical paddle-door motor.
- Sequences open travel, hold, passenger passage, close travel, obstruction re-open and a latched fault.
- Counts passengers and flags tailgating.
- Returns `door_busy` so the gate FSM can ignore new taps while the door is in motion or open.

Parameters:
- OPEN_TRAVEL, 3: cycles motor_open is asserted to reach fully open.
- CLOSE_TRAVEL, 3: cycles motor_close is asserted to reach fully closed.
- HOLD_CYCLES, 20: maximum cycles held open waiting for a passenger.
- MAX_REOPEN, 2: obstruction re-opens allowed per entry before FAULT.
- CNT_W, 16: pass_count width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- open  in  1  door-open request from the gate FSM (level; sampled each cycle)
- maintenance  in  1  maintenance mode; also the only FAULT clear
- passage_sensor  in  1  beam broken by a passenger in the gate aisle
- obstruction  in  1  door-edge obstruction switch
- motor_open  out  1  drive door toward open
- motor_close  out  1  drive door toward closed
- door_busy  out  1  high in every state except CLOSED
- door_state  out  3  encoded current state (gate_door_pkg::door_state_t)
- tailgate  out  1  one-cycle pulse on a second passenger in one entry
- fault  out  1  high while in FAULT
- pass_count  out  CNT_W  passengers passed since reset

Behaviour:
- Reset (synchronous; `reset` high at an edge):
  - state = CLOSED; all outputs 0; pass_count = 0; timers, reopen counter and passed flag = 0.
  - Reset wins over every other input.
  - Reset mid-motion drops both motor outputs on the next edge.
- Registered outputs: motor_open, motor_close, fault and door_busy are decoded from the registered state.
  - They are valid the cycle after a state change.
  - motor_open and motor_close are never both high.
- Passage detection: a rising edge of passage_sensor is detected against a registered previous value.
- CLOSED:
  - open=1 and maintenance=0 -> OPENING, timer loaded.
  - Latency: open sampled high at edge n -> motor_open high after edge n; reopen counter and passed flag cleared.
  - maintenance=1: open is ignored.
- OPENING:
  - motor_open=1 for exactly OPEN_TRAVEL cycles, then HELD; HOLD timer loaded.
  - Obstruction is ignored while opening.
- HELD:
  - Passage rising edge with passed=0: set passed, increment pass_count (wraps at 2^CNT_W-1 -> 0).
  - Passage rising edge with passed=1: pulse tailgate and still increment pass_count.
  - passed=1 and passage_sensor=0 -> CLOSING on the next edge.
  - HOLD timer expires with no passenger -> CLOSING.
  - open re-asserted in HELD does not extend the hold.
- CLOSING:
  - motor_close=1 for CLOSE_TRAVEL cycles, then CLOSED.
  - obstruction=1 with reopen count < MAX_REOPEN -> OPENING, reopen count +1; the passed flag is kept, so the same passenger is not recounted.
  - obstruction=1 with reopen count = MAX_REOPEN -> FAULT.
  - If obstruction and travel-complete fall in the same cycle, obstruction wins.
- FAULT:
  - Both motor outputs 0; fault=1; door_busy=1.
  - Stays in FAULT until maintenance=1 at an edge, then CLOSING (re-close attempt with reopen count cleared).
- Maintenance asserted in OPENING, HELD or CLOSING does not interrupt the sequence; it only blocks new entries from CLOSED.
- Timers: one down-counter of width $clog2(max(OPEN_TRAVEL, CLOSE_TRAVEL, HOLD_CYCLES)+1), reloaded on every state entry; expiry when the count reaches 1.

Decomposition:
- Package gate_door_pkg:
  - door_state_t enum (CLOSED=0, OPENING=1, HELD=2, CLOSING=3, FAULT=4).
  - Shared display-code constants, so the gate FSM and this block agree on encodings.
- One sub-module, edge_detect_rise (1-bit registered rising-edge detector), used for passage_sensor.
- The rest is a single FSM plus counters.

Test Plan:
- Happy path: open pulsed 1 cycle from CLOSED -> motor_open high 3 cycles; HELD; passage_sensor high 4 cycles then low -> pass_count=1; CLOSING 3 cycles; CLOSED with door_busy=0.
- No passenger: open pulse, no passage -> HELD lasts exactly 20 cycles, then CLOSING and CLOSED; pass_count stays 0.
- Tailgate: two separate passage_sensor pulses in HELD -> tailgate pulses once, on the second rising edge; pass_count=2.
- Obstruction: obstruction during CLOSING, twice -> two re-opens, then CLOSED; a third obstruction in the same entry -> FAULT with fault=1 and motors 0; maintenance=1 for 1 cycle -> CLOSING, then CLOSED.
- Maintenance and busy: maintenance=1 with open=1 in CLOSED -> stays CLOSED; open asserted during HELD does not extend the hold.
- Reset mid-operation: reset asserted during OPENING cycle 2 -> next edge: CLOSED, motor_open=0, pass_count=0.
- Wrap: with CNT_W=2, four passengers -> pass_count goes 1, 2, 3, 0.

Source files
------------

// File: rtl/gate_door_pkg.sv
// Shared encodings for the paddle-door controller and the upstream gate FSM.
package gate_door_pkg;

  localparam int unsigned DOOR_STATE_W = 3;

  typedef enum logic [DOOR_STATE_W-1:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    HELD    = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } door_state_t;

  // Display codes the gate FSM shows for each door state.
  localparam logic [DOOR_STATE_W-1:0] DISP_CLOSED  = 3'd0;
  localparam logic [DOOR_STATE_W-1:0] DISP_OPENING = 3'd1;
  localparam logic [DOOR_STATE_W-1:0] DISP_HELD    = 3'd2;
  localparam logic [DOOR_STATE_W-1:0] DISP_CLOSING = 3'd3;
  localparam logic [DOOR_STATE_W-1:0] DISP_FAULT   = 3'd4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// One-bit rising-edge detector against a registered previous sample.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/gate_door_ctrl.sv
// Paddle-door motor sequencer: open travel, hold, passage, close travel,
// obstruction re-open and latched fault, plus passenger counting.
module gate_door_ctrl
  import gate_door_pkg::*;
#(
  parameter int unsigned OPEN_TRAVEL  = 3,
  parameter int unsigned CLOSE_TRAVEL = 3,
  parameter int unsigned HOLD_CYCLES  = 20,
  parameter int unsigned MAX_REOPEN   = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             open,
  input  logic             maintenance,
  input  logic             passage_sensor,
  input  logic             obstruction,
  output logic             motor_open,
  output logic             motor_close,
  output logic             door_busy,
  output door_state_t      door_state,
  output logic             tailgate,
  output logic             fault,
  output logic [CNT_W-1:0] pass_count
);

  localparam int unsigned TMR_W = $clog2(max3(OPEN_TRAVEL, CLOSE_TRAVEL, HOLD_CYCLES) + 1);
  localparam int unsigned RO_W  = $clog2(MAX_REOPEN + 2);

  door_state_t      state_q;
  logic [TMR_W-1:0] timer_q;
  logic [RO_W-1:0]  reopen_q;
  logic             passed_q;
  logic             tailgate_q;
  logic [CNT_W-1:0] count_q;
  logic             pass_rise;
  logic             expired;

  edge_detect_rise u_pass_edge (
    .clk    (clk),
    .reset  (reset),
    .d_i    (passage_sensor),
    .rise_o (pass_rise)
  );

  assign expired = (timer_q == TMR_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLOSED;
      timer_q    <= '0;
      reopen_q   <= '0;
      passed_q   <= 1'b0;
      tailgate_q <= 1'b0;
      count_q    <= '0;
    end else begin
      tailgate_q <= 1'b0;
      // Timer holds at 1 so a passenger still in the aisle keeps the door open.
      if (timer_q > TMR_W'(1)) timer_q <= timer_q - TMR_W'(1);
      case (state_q)
        CLOSED: begin
          if (open && !maintenance) begin
            state_q  <= OPENING;
            timer_q  <= TMR_W'(OPEN_TRAVEL);
            reopen_q <= '0;
            passed_q <= 1'b0;
          end
        end
        OPENING: begin
          if (expired) begin
            state_q <= HELD;
            timer_q <= TMR_W'(HOLD_CYCLES);
          end
        end
        HELD: begin
          if (pass_rise) begin
            count_q  <= count_q + CNT_W'(1);
            passed_q <= 1'b1;
            if (passed_q) tailgate_q <= 1'b1;
          end
          if ((passed_q && !passage_sensor) || (!passed_q && !pass_rise && expired)) begin
            state_q <= CLOSING;
            timer_q <= TMR_W'(CLOSE_TRAVEL);
          end
        end
        CLOSING: begin
          if (obstruction) begin
            if (reopen_q < RO_W'(MAX_REOPEN)) begin
              state_q  <= OPENING;
              timer_q  <= TMR_W'(OPEN_TRAVEL);
              reopen_q <= reopen_q + RO_W'(1);
            end else begin
              state_q <= FAULT;
              timer_q <= '0;
            end
          end else if (expired) begin
            state_q <= CLOSED;
            timer_q <= '0;
          end
        end
        FAULT: begin
          if (maintenance) begin
            state_q  <= CLOSING;
            timer_q  <= TMR_W'(CLOSE_TRAVEL);
            reopen_q <= '0;
          end
        end
        default: state_q <= CLOSED;
      endcase
    end
  end

  assign motor_open  = (state_q == OPENING);
  assign motor_close = (state_q == CLOSING);
  assign door_busy   = (state_q != CLOSED);
  assign fault       = (state_q == FAULT);
  assign door_state  = state_q;
  assign tailgate    = tailgate_q;
  assign pass_count  = count_q;

endmodule

// File: tb/tb_gate_door_ctrl.sv
// Directed bench for gate_door_ctrl; a second 2-bit-counter instance checks wrap.
module tb_gate_door_ctrl;
  import gate_door_pkg::*;

  logic clk = 1'b0;
  logic reset, open, maintenance, passage_sensor, obstruction;
  logic motor_open, motor_close, door_busy, tailgate, fault;
  door_state_t door_state;
  logic [15:0] pass_count;
  logic w_motor_open, w_motor_close, w_door_busy, w_tailgate, w_fault;
  door_state_t w_door_state;
  logic [1:0] w_pass_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int tg_pulses = 0;

  always #5 clk = ~clk;

  gate_door_ctrl dut (
    .clk(clk), .reset(reset), .open(open), .maintenance(maintenance),
    .passage_sensor(passage_sensor), .obstruction(obstruction),
    .motor_open(motor_open), .motor_close(motor_close), .door_busy(door_busy),
    .door_state(door_state), .tailgate(tailgate), .fault(fault), .pass_count(pass_count)
  );

  gate_door_ctrl #(.CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .open(open), .maintenance(maintenance),
    .passage_sensor(passage_sensor), .obstruction(obstruction),
    .motor_open(w_motor_open), .motor_close(w_motor_close), .door_busy(w_door_busy),
    .door_state(w_door_state), .tailgate(w_tailgate), .fault(w_fault), .pass_count(w_pass_count)
  );

  always @(negedge clk) if (tailgate === 1'b1) tg_pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_open();
    open = 1'b1; step(); open = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_pass();
    passage_sensor = 1'b1; step(); passage_sensor = 1'b0; step();
    exp_cnt++;
  endtask

  task automatic obstruct();
    obstruction = 1'b1; step(); obstruction = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; open = 1'b1; maintenance = 1'b0; passage_sensor = 1'b0; obstruction = 1'b0;
    repeat (2) step();
    reset = 1'b0; open = 1'b0;
    checks++; if (door_state !== CLOSED) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", door_state, CLOSED); end
    checks++; if ({motor_open, motor_close, door_busy, fault, tailgate} !== 5'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=00000", {motor_open, motor_close, door_busy, fault, tailgate}); end
    checks++; if (pass_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", pass_count); end
  endtask

  task automatic test_happy();
    open = 1'b1; step(); open = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (door_state !== OPENING || motor_open !== 1'b1 || motor_close !== 1'b0) begin errors++; $display("FAIL happy_opening cyc=%0d got state=%0d mo=%b mc=%b exp state=1 mo=1 mc=0", i, door_state, motor_open, motor_close); end
      step();
    end
    checks++; if (door_state !== HELD || motor_open !== 1'b0) begin errors++; $display("FAIL happy_held got state=%0d mo=%b exp state=2 mo=0", door_state, motor_open); end
    passage_sensor = 1'b1; step(); exp_cnt++;
    checks++; if (pass_count !== 16'(exp_cnt)) begin errors++; $display("FAIL happy_count got=%0d exp=%0d", pass_count, exp_cnt); end
    repeat (3) step();
    checks++; if (door_state !== HELD) begin errors++; $display("FAIL happy_aisle_hold got=%0d exp=2", door_state); end
    passage_sensor = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (door_state !== CLOSING || motor_close !== 1'b1 || motor_open !== 1'b0) begin errors++; $display("FAIL happy_closing cyc=%0d got state=%0d mc=%b exp state=3 mc=1", i, door_state, motor_close); end
      step();
    end
    checks++; if (door_state !== CLOSED || door_busy !== 1'b0 || pass_count !== 16'(exp_cnt)) begin errors++; $display("FAIL happy_closed got state=%0d busy=%b cnt=%0d exp state=0 busy=0 cnt=%0d", door_state, door_busy, pass_count, exp_cnt); end
  endtask

  task automatic test_no_passenger();
    int n;
    do_open();
    n = 0;
    while (door_state === HELD && n < 100) begin n++; step(); end
    checks++; if (n != 20) begin errors++; $display("FAIL nopass_hold_len got=%0d exp=20", n); end
    checks++; if (door_state !== CLOSING) begin errors++; $display("FAIL nopass_closing got=%0d exp=3", door_state); end
    repeat (3) step();
    checks++; if (door_state !== CLOSED || pass_count !== 16'(exp_cnt)) begin errors++; $display("FAIL nopass_closed got state=%0d cnt=%0d exp state=0 cnt=%0d", door_state, pass_count, exp_cnt); end
  endtask

  task automatic test_tailgate();
    do_open();
    passage_sensor = 1'b1; step(); exp_cnt++;
    checks++; if (tailgate !== 1'b0) begin errors++; $display("FAIL tg_first got=%b exp=0", tailgate); end
    passage_sensor = 1'b0; step();
    obstruct();
    checks++; if (door_state !== OPENING) begin errors++; $display("FAIL tg_reopen got=%0d exp=1", door_state); end
    repeat (3) step();
    passage_sensor = 1'b1; step(); exp_cnt++;
    checks++; if (tailgate !== 1'b1 || pass_count !== 16'(exp_cnt)) begin errors++; $display("FAIL tg_second got tg=%b cnt=%0d exp tg=1 cnt=%0d", tailgate, pass_count, exp_cnt); end
    step();
    checks++; if (tailgate !== 1'b0 || door_state !== HELD) begin errors++; $display("FAIL tg_pulse_end got tg=%b state=%0d exp tg=0 state=2", tailgate, door_state); end
    passage_sensor = 1'b0; step();
    repeat (3) step();
    checks++; if (door_state !== CLOSED || tg_pulses != 1) begin errors++; $display("FAIL tg_total got state=%0d pulses=%0d exp state=0 pulses=1", door_state, tg_pulses); end
  endtask

  task automatic test_obstruction();
    do_open(); do_pass();
    obstruct();
    obstruction = 1'b1; step(); obstruction = 1'b0;
    checks++; if (door_state !== OPENING) begin errors++; $display("FAIL obs_ignored_opening got=%0d exp=1", door_state); end
    repeat (2) step(); step();
    obstruct();
    checks++; if (door_state !== OPENING) begin errors++; $display("FAIL obs_reopen2 got=%0d exp=1", door_state); end
    repeat (3) step(); step();
    checks++; if (door_state !== CLOSING || pass_count !== 16'(exp_cnt)) begin errors++; $display("FAIL obs_no_recount got state=%0d cnt=%0d exp state=3 cnt=%0d", door_state, pass_count, exp_cnt); end
    repeat (3) step();
    checks++; if (door_state !== CLOSED) begin errors++; $display("FAIL obs_closed got=%0d exp=0", door_state); end
    do_open(); do_pass();
    obstruct(); repeat (3) step(); step();
    obstruct(); repeat (3) step(); step();
    repeat (2) step();
    obstruct();
    checks++; if (door_state !== FAULT || fault !== 1'b1 || motor_open !== 1'b0 || motor_close !== 1'b0 || door_busy !== 1'b1) begin errors++; $display("FAIL obs_fault got state=%0d f=%b mo=%b mc=%b busy=%b exp state=4 f=1 mo=0 mc=0 busy=1", door_state, fault, motor_open, motor_close, door_busy); end
    open = 1'b1; repeat (4) step(); open = 1'b0;
    checks++; if (door_state !== FAULT) begin errors++; $display("FAIL fault_latched got=%0d exp=4", door_state); end
    maintenance = 1'b1; step(); maintenance = 1'b0;
    checks++; if (door_state !== CLOSING || fault !== 1'b0) begin errors++; $display("FAIL fault_clear got state=%0d f=%b exp state=3 f=0", door_state, fault); end
    repeat (3) step();
    checks++; if (door_state !== CLOSED) begin errors++; $display("FAIL fault_reclose got=%0d exp=0", door_state); end
  endtask

  task automatic test_maint_busy();
    int n;
    maintenance = 1'b1; open = 1'b1; repeat (3) step();
    checks++; if (door_state !== CLOSED || door_busy !== 1'b0) begin errors++; $display("FAIL maint_block got state=%0d busy=%b exp state=0 busy=0", door_state, door_busy); end
    maintenance = 1'b0; step();
    checks++; if (door_state !== OPENING) begin errors++; $display("FAIL maint_release got=%0d exp=1", door_state); end
    repeat (3) step();
    n = 0;
    while (door_state === HELD && n < 100) begin n++; step(); end
    open = 1'b0;
    checks++; if (n != 20) begin errors++; $display("FAIL open_no_extend got=%0d exp=20", n); end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    open = 1'b1; step(); open = 1'b0; step();
    reset = 1'b1; step(); reset = 1'b0;
    exp_cnt = 0;
    checks++; if (door_state !== CLOSED || motor_open !== 1'b0 || pass_count !== 16'd0) begin errors++; $display("FAIL reset_mid got state=%0d mo=%b cnt=%0d exp state=0 mo=0 cnt=0", door_state, motor_open, pass_count); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w;
    for (int i = 0; i < 4; i++) begin
      do_open(); do_pass(); repeat (3) step();
      exp_w = 2'(i + 1);
      checks++; if (w_pass_count !== exp_w || pass_count !== 16'(i + 1)) begin errors++; $display("FAIL wrap_count i=%0d got w=%0d main=%0d exp w=%0d main=%0d", i, w_pass_count, pass_count, exp_w, i + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_no_passenger();
    test_tailgate();
    test_obstruction();
    test_maint_busy();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
